// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: shared types, default vectors and alignment helper for pc_sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {BOOT, RUN, WAIT, HALT} state_t;
    typedef enum logic [1:0] {SRC_TRAP, SRC_REDIR, SRC_HOLD, SRC_SEQ} src_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

    // Low PC bits that must be zero for an instruction of size INC.
    function automatic logic [1:0] align_mask(input int inc);
        return (inc == 2) ? 2'b01 : 2'b11;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch handshake between the PC sequencer (master) and instruction memory (slave).
interface pc_sequencer_if #(parameter int XLEN = 32);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] fetch_pc;
    modport master (output fetch_valid, fetch_pc, input fetch_ready);
    modport slave  (input fetch_valid, fetch_pc, output fetch_ready);
endinterface

// File: rtl/pc_sequencer_history_buf.sv
// pc_history_buf: circular buffer of pre-redirect PCs; index 0 reads the newest entry.
module pc_history_buf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       we,
    input  logic [XLEN-1:0]            wpc,
    input  logic [$clog2(DEPTH)-1:0]   hist_idx,
    output logic [XLEN-1:0]            hist_pc,
    output logic [$clog2(DEPTH):0]     hist_count
);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   ra;

    always_ff @(posedge CLK) begin
        if (we)
            mem[wptr] <= wpc;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr       <= '0;
            hist_count <= '0;
        end else if (we) begin
            wptr <= wptr + AW'(1);
            if (hist_count != (AW+1)'(DEPTH))
                hist_count <= hist_count + (AW+1)'(1);
        end
    end

    // DEPTH is a power of two, so the pointer arithmetic wraps naturally.
    always_comb begin
        ra      = wptr - AW'(1) - hist_idx;
        hist_pc = ({1'b0, hist_idx} < hist_count) ? mem[ra] : '0;
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC with trap/redirect/halt sequencing and a valid/ready fetch port.
// Define PC_SEQ_HISTORY_EN to add the redirect-history buffer and its hist_* ports.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
    parameter int              INC          = 4,
    parameter int              HIST_DEPTH   = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    input  logic                   trap_valid,
    input  logic                   halt_req,
    input  logic                   resume,
    pc_sequencer_if.master         fetch,
    output logic                   misaligned,
    output logic                   halted
`ifdef PC_SEQ_HISTORY_EN
    ,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [XLEN-1:0]               hist_pc,
    output logic [$clog2(HIST_DEPTH):0]   hist_count
`endif
);
    localparam logic [XLEN-1:0] MASK = XLEN'(align_mask(INC));

    state_t          state, state_next;
    src_t            src;
    logic [XLEN-1:0] pc, pc_next;
    logic            mis_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= BOOT;
            pc         <= RESET_VECTOR;
            misaligned <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            misaligned <= mis_next;
        end
    end

    // Trap beats everything; in HALT only trap and resume are looked at.
    always_comb begin
        state_next = state;
        src        = SRC_HOLD;
        unique case (state)
            BOOT: state_next = RUN;
            HALT: begin
                if (trap_valid) begin
                    src        = SRC_TRAP;
                    state_next = RUN;
                end else if (resume) begin
                    state_next = RUN;
                end
            end
            default: begin
                if (trap_valid) begin
                    src        = SRC_TRAP;
                    state_next = RUN;
                end else if (redirect_valid) begin
                    src        = SRC_REDIR;
                    state_next = RUN;
                end else if (halt_req) begin
                    state_next = HALT;
                end else if (!fetch.fetch_ready) begin
                    state_next = WAIT;
                end else begin
                    state_next = RUN;
                    src        = stall ? SRC_HOLD : SRC_SEQ;
                end
            end
        endcase
    end

    always_comb begin
        pc_next = (src == SRC_TRAP)  ? TRAP_VECTOR :
                  (src == SRC_REDIR) ? (redirect_pc & ~MASK) :
                  (src == SRC_SEQ)   ? pc + XLEN'(INC) : pc;
        mis_next          = (src == SRC_REDIR) && |(redirect_pc & MASK);
        fetch.fetch_valid = (state == RUN) || (state == WAIT);
        fetch.fetch_pc    = pc;
        halted            = (state == HALT);
    end

`ifdef PC_SEQ_HISTORY_EN
    logic hist_we;
    assign hist_we = (src == SRC_TRAP) || (src == SRC_REDIR);

    pc_history_buf #(.XLEN(XLEN), .DEPTH(HIST_DEPTH)) u_hist (
        .CLK        (CLK),
        .RST        (RST),
        .we         (hist_we),
        .wpc        (pc),
        .hist_idx   (hist_idx),
        .hist_pc    (hist_pc),
        .hist_count (hist_count)
    );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plan plus randomized control traffic against a behavioural PC model.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RST, stall, redirect_valid, trap_valid, halt_req, resume, fetch_ready;
    logic [31:0] redirect_pc;
    logic        mis0, mis1, hlt0, hlt1;
    int          checks = 0;
    int          passed = 0;

    pc_sequencer_if #(.XLEN(32)) f0 ();
    pc_sequencer_if #(.XLEN(32)) f1 ();
    assign f0.fetch_ready = fetch_ready;
    assign f1.fetch_ready = fetch_ready;

`ifdef PC_SEQ_HISTORY_EN
    logic [2:0]  hist_idx = '0;
    logic [31:0] hp0, hp1;
    logic [3:0]  hc0, hc1;
`endif

    pc_sequencer dut (
        .CLK(CLK), .RST(RST), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .trap_valid(trap_valid), .halt_req(halt_req),
        .resume(resume), .fetch(f0), .misaligned(mis0), .halted(hlt0)
`ifdef PC_SEQ_HISTORY_EN
        , .hist_idx(hist_idx), .hist_pc(hp0), .hist_count(hc0)
`endif
    );

    pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_wrap (
        .CLK(CLK), .RST(RST), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .trap_valid(trap_valid), .halt_req(halt_req),
        .resume(resume), .fetch(f1), .misaligned(mis1), .halted(hlt1)
`ifdef PC_SEQ_HISTORY_EN
        , .hist_idx(hist_idx), .hist_pc(hp1), .hist_count(hc1)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference model: an architectural PC plus "still booting" and "halted" flags.
    logic [31:0] rv [2] = '{32'h0000_0000, 32'hFFFF_FFF8};
    logic [31:0] m_pc [2];
    bit          m_boot [2], m_halt [2], m_mis [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_step(input int i);
        m_mis[i] = 1'b0;
        if (RST) begin
            m_pc[i] = rv[i]; m_boot[i] = 1'b1; m_halt[i] = 1'b0;
        end else if (m_boot[i]) begin
            m_boot[i] = 1'b0;
        end else if (trap_valid) begin
            m_pc[i] = 32'h100; m_halt[i] = 1'b0;
        end else if (m_halt[i]) begin
            if (resume) m_halt[i] = 1'b0;
        end else if (redirect_valid) begin
            m_pc[i]  = redirect_pc / 4 * 4;
            m_mis[i] = (redirect_pc % 4) != 0;
        end else if (halt_req) begin
            m_halt[i] = 1'b1;
        end else if (!stall && fetch_ready) begin
            m_pc[i] = m_pc[i] + 32'd4;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_step(0);
        model_step(1);
        #1;
        check("m0_valid", 32'(f0.fetch_valid), 32'(!m_boot[0] && !m_halt[0]));
        check("m0_pc",    f0.fetch_pc,         m_pc[0]);
        check("m0_halted", 32'(hlt0),          32'(m_halt[0]));
        check("m0_mis",   32'(mis0),           32'(m_mis[0]));
        check("m1_valid", 32'(f1.fetch_valid), 32'(!m_boot[1] && !m_halt[1]));
        check("m1_pc",    f1.fetch_pc,         m_pc[1]);
        check("m1_halted", 32'(hlt1),          32'(m_halt[1]));
        check("m1_mis",   32'(mis1),           32'(m_mis[1]));
    endtask

    task automatic idle();
        stall = 0; redirect_valid = 0; trap_valid = 0; halt_req = 0; resume = 0;
        redirect_pc = '0; fetch_ready = 1;
    endtask

    initial begin
        RST = 1; idle();
        step(); step();
        check("reset_valid", 32'(f0.fetch_valid), 32'd0);
        check("reset_pc", f0.fetch_pc, 32'h0);
        check("reset_halted", 32'(hlt0), 32'd0);
        check("reset_mis", 32'(mis0), 32'd0);
        RST = 0;
        step(); check("t1_pc0", f0.fetch_pc, 32'h0); check("t1_valid", 32'(f0.fetch_valid), 32'd1);
        check("t5_pc0", f1.fetch_pc, 32'hFFFF_FFF8);
        step(); check("t1_pc4", f0.fetch_pc, 32'h4); check("t5_pc1", f1.fetch_pc, 32'hFFFF_FFFC);
        step(); check("t1_pc8", f0.fetch_pc, 32'h8); check("t5_wrap", f1.fetch_pc, 32'h0);
        fetch_ready = 0;
        for (int k = 0; k < 3; k++) begin
            step(); check("t2_hold", f0.fetch_pc, 32'h8); check("t2_valid", 32'(f0.fetch_valid), 32'd1);
        end
        fetch_ready = 1;
        step(); check("t2_adv", f0.fetch_pc, 32'hC);
        stall = 1; redirect_valid = 1; redirect_pc = 32'h40;
        step(); check("t3_redir", f0.fetch_pc, 32'h40);
        trap_valid = 1;
        step(); check("t3_trap", f0.fetch_pc, 32'h100);
        idle(); redirect_valid = 1; redirect_pc = 32'h42;
        step(); check("t4_align", f0.fetch_pc, 32'h40); check("t4_mis", 32'(mis0), 32'd1);
        idle();
        step(); check("t4_mis_end", 32'(mis0), 32'd0); check("t4_seq", f0.fetch_pc, 32'h44);
        redirect_valid = 1; redirect_pc = 32'h10;
        step(); check("t6_at10", f0.fetch_pc, 32'h10);
        idle(); halt_req = 1;
        step(); check("t6_halted", 32'(hlt0), 32'd1); check("t6_novalid", 32'(f0.fetch_valid), 32'd0);
        halt_req = 0; redirect_valid = 1; redirect_pc = 32'h80;
        step(); check("t6_ignore_redir", f0.fetch_pc, 32'h10);
        idle(); resume = 1;
        step(); check("t6_resume_pc", f0.fetch_pc, 32'h10); check("t6_resume_halted", 32'(hlt0), 32'd0);
        idle();
        step(); check("t6_after", f0.fetch_pc, 32'h14);
`ifdef PC_SEQ_HISTORY_EN
        begin
            logic [31:0] last_pre;
            last_pre = '0;
            for (int k = 0; k < 9; k++) begin
                redirect_valid = 1; redirect_pc = 32'h200 + 32'(k) * 32'h10;
                last_pre = m_pc[0];
                step();
            end
            idle(); hist_idx = 0; #1;
            check("hist_count", 32'(hc0), 32'd8);
            check("hist_newest", hp0, last_pre);
        end
`endif
        for (int n = 0; n < 600; n++) begin
            RST            = ($urandom_range(0, 99) < 2);
            stall          = ($urandom_range(0, 99) < 20);
            fetch_ready    = ($urandom_range(0, 99) < 70);
            redirect_valid = ($urandom_range(0, 99) < 12);
            trap_valid     = ($urandom_range(0, 99) < 4);
            halt_req       = ($urandom_range(0, 99) < 6);
            resume         = ($urandom_range(0, 99) < 30);
            redirect_pc    = $urandom;
            step();
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
